// File: rtl/redun_mont_pkg.sv
// Shared types and constants for the redundant-form Montgomery result path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: word/result widths, modulus P, redundant word and result types,
// one-hot FSM state encodings used by redun_mont_result.
package redun_mont_pkg;

    localparam int NUM_WRDS = 2;
    localparam int WRD_BITS = 8;
    localparam int DAT_BITS = NUM_WRDS * WRD_BITS;
    localparam int IDX_BITS = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;

    localparam logic [DAT_BITS-1:0] P = 16'hC001;

    // One redundant word carries one spare bit above the non-redundant width.
    typedef logic [WRD_BITS:0]   rwrd_t;
    typedef logic [DAT_BITS-1:0] res_t;

    typedef logic [4:0] state_t;
    localparam state_t ST_IDLE   = 5'b00001;
    localparam state_t ST_COUNT  = 5'b00010;
    localparam state_t ST_PROP   = 5'b00100;
    localparam state_t ST_REDUCE = 5'b01000;
    localparam state_t ST_OUT    = 5'b10000;

endpackage

// File: rtl/redun_carry_prop.sv
// Word-serial carry propagation of a redundant result into a binary accumulator.
// Latency: combinational acc update per word; one word per step, carry registered.
// Backpressure: none; the caller sequences start/step and the word index.
//
// Ports: clk, rst_n (async active-low), start (clear carry), step (advance
// carry), idx (word being folded), words (captured redundant result),
// acc_in (current accumulator), acc_out (accumulator with word idx folded in).
module redun_carry_prop
    import redun_mont_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               step,
    input  logic [IDX_BITS-1:0]                idx,
    input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]   words,
    input  logic [DAT_BITS:0]                  acc_in,
    output logic [DAT_BITS:0]                  acc_out
);

    logic  carry;
    rwrd_t cur;
    rwrd_t sum;

    always_comb begin
        cur     = words[idx*(WRD_BITS+1) +: WRD_BITS+1];
        sum     = cur + {{WRD_BITS{1'b0}}, carry};
        acc_out = acc_in;
        // Writing WRD_BITS+1 bits lets the spare bit land where the next word
        // starts; the next word overwrites it with its own sum, and the last
        // word's spare bit ends up in acc[DAT_BITS].
        acc_out[idx*WRD_BITS +: WRD_BITS+1] = sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (start) begin
            carry <= 1'b0;
        end else if (step) begin
            carry <= sum[WRD_BITS];
        end
    end

endmodule

// File: rtl/redun_mont_result.sv
// Captures the T-th squarer result, converts it to binary and reduces it below P.
// Latency: 1 + NUM_WRDS + (subtractions + 1) cycles from the capturing pulse to o_val.
// Backpressure: o_val/o_dat hold in OUT until i_rdy; squarer pulses outside COUNT are dropped.
//
// Ports: i_clk, i_rst_n (async active-low), i_start/i_iter (start a run of T
// squarings), i_mul/i_mul_val (squarer output), o_busy, o_dat/o_val/i_rdy
// (result handshake), o_err (one-cycle pulse: zero T or reduction overrun).
module redun_mont_result
    import redun_mont_pkg::*;
#(
    parameter int MAX_SUB   = 4,
    parameter int ITER_BITS = 64
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_start,
    input  logic [ITER_BITS-1:0]               i_iter,
    input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]   i_mul,
    input  logic                               i_mul_val,
    output logic                               o_busy,
    output logic [DAT_BITS-1:0]                o_dat,
    output logic                               o_val,
    input  logic                               i_rdy,
    output logic                               o_err
);

    localparam int                SUB_BITS = $clog2(MAX_SUB + 1);
    localparam logic [DAT_BITS:0] P_EXT    = {1'b0, P};

    state_t                              state;
    logic [ITER_BITS-1:0]                iter_t;
    logic [ITER_BITS-1:0]                cnt;
    logic [NUM_WRDS*(WRD_BITS+1)-1:0]    cap;
    logic [DAT_BITS:0]                   acc;
    logic [DAT_BITS:0]                   prop_acc;
    logic [IDX_BITS-1:0]                 prop_idx;
    logic [SUB_BITS-1:0]                 sub_cnt;
    logic                                cnt_hit;
    logic                                prop_start;
    logic                                prop_step;
    logic                                prop_last;
    logic                                acc_ge_p;

    assign o_busy     = (state != ST_IDLE);
    assign cnt_hit    = ((cnt + ITER_BITS'(1)) == iter_t);
    assign prop_start = (state == ST_COUNT) && i_mul_val && cnt_hit;
    assign prop_step  = (state == ST_PROP);
    assign prop_last  = (prop_idx == IDX_BITS'(NUM_WRDS - 1));
    assign acc_ge_p   = (acc >= P_EXT);

    redun_carry_prop u_prop (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .start   (prop_start),
        .step    (prop_step),
        .idx     (prop_idx),
        .words   (cap),
        .acc_in  (acc),
        .acc_out (prop_acc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            iter_t   <= '0;
            cnt      <= '0;
            cap      <= '0;
            acc      <= '0;
            prop_idx <= '0;
            sub_cnt  <= '0;
            o_val    <= 1'b0;
            o_dat    <= '0;
            o_err    <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_iter != '0) begin
                            iter_t <= i_iter;
                            cnt    <= '0;
                            state  <= ST_COUNT;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                ST_COUNT: begin
                    // cnt never passes iter_t: the run leaves COUNT on the hit.
                    if (i_mul_val) begin
                        cnt <= cnt + ITER_BITS'(1);
                        if (cnt_hit) begin
                            cap      <= i_mul;
                            acc      <= '0;
                            prop_idx <= '0;
                            state    <= ST_PROP;
                        end
                    end
                end
                ST_PROP: begin
                    acc <= prop_acc;
                    if (prop_last) begin
                        sub_cnt <= '0;
                        state   <= ST_REDUCE;
                    end else begin
                        prop_idx <= prop_idx + 1'b1;
                    end
                end
                ST_REDUCE: begin
                    if (acc_ge_p) begin
                        // Still not reduced after the allowed number of
                        // subtractions: the input was out of range, drop it.
                        if (sub_cnt == SUB_BITS'(MAX_SUB)) begin
                            o_err <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            acc     <= acc - P_EXT;
                            sub_cnt <= sub_cnt + 1'b1;
                        end
                    end else begin
                        o_val <= 1'b1;
                        o_dat <= acc[DAT_BITS-1:0];
                        state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (i_rdy) begin
                        o_val <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redun_mont_result.sv
// Directed bench for redun_mont_result: default instance plus a MAX_SUB=1 twin
// sharing the same stimulus, used to exercise the reduction overrun error.
module tb_redun_mont_result;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] iter;
    logic [17:0] mul;
    logic        mul_val;
    logic        rdy;

    logic        busy,   e_busy;
    logic [15:0] dat,    e_dat;
    logic        val,    e_val;
    logic        err,    e_err;

    int checks = 0;
    int errors = 0;
    int lat;
    int lat_a, lat_e, nerr, nval_e;
    logic [15:0] dat_a;

    always #5 clk = ~clk;

    redun_mont_result #(.MAX_SUB(4), .ITER_BITS(64)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_iter(iter),
        .i_mul(mul), .i_mul_val(mul_val), .o_busy(busy), .o_dat(dat),
        .o_val(val), .i_rdy(rdy), .o_err(err)
    );

    redun_mont_result #(.MAX_SUB(1), .ITER_BITS(64)) dut_e (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_iter(iter),
        .i_mul(mul), .i_mul_val(mul_val), .o_busy(e_busy), .o_dat(e_dat),
        .o_val(e_val), .i_rdy(rdy), .o_err(e_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One non-capturing squarer pulse followed by an idle cycle.
    task automatic pulse(input logic [8:0] w1, input logic [8:0] w0);
        mul     = {w1, w0};
        mul_val = 1'b1;
        cyc();
        mul_val = 1'b0;
        cyc();
    endtask

    // Drive the capturing pulse (cycle 0) and report in which later cycle
    // o_val is first seen high (99 if never within the budget).
    task automatic capture(input logic [8:0] w1, input logic [8:0] w0, output int l);
        mul     = {w1, w0};
        mul_val = 1'b1;
        @(negedge clk);
        chk("cap_cycle_val", 32'(val), 32'd0);
        cyc();
        mul_val = 1'b0;
        mul     = 18'h2AAAA;
        l = 99;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (val) begin
                l = n;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; iter = '0; mul = '0; mul_val = 1'b0; rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_val",  32'(val),  32'd0);
        chk("rst_err",  32'(err),  32'd0);
        chk("rst_dat",  32'(dat),  32'd0);
        cyc();
        rst_n = 1'b1;

        // Basic capture on the third pulse, no subtraction.
        start = 1'b1; iter = 64'd3; cyc(); start = 1'b0;
        pulse(9'h1AA, 9'h155);
        pulse(9'h0F0, 9'h00F);
        capture(9'h010, 9'h005, lat);
        chk("basic_lat", 32'(lat), 32'd4);
        chk("basic_dat", 32'(dat), 32'h1005);
        @(negedge clk);
        chk("basic_done_val",  32'(val),  32'd0);
        chk("basic_done_busy", 32'(busy), 32'd0);
        cyc();

        // Carry out of word 0 into the top bit, then one subtraction.
        start = 1'b1; iter = 64'd1; cyc(); start = 1'b0;
        capture(9'h0FF, 9'h1FF, lat);
        chk("onesub_lat",   32'(lat),   32'd5);
        chk("onesub_dat",   32'(dat),   32'h40FE);
        chk("onesub_e_val", 32'(e_val), 32'd1);
        chk("onesub_e_dat", 32'(e_dat), 32'h40FE);
        cyc();

        // Backpressure: hold in OUT for 10 cycles with stray pulses and starts.
        rdy = 1'b0;
        start = 1'b1; iter = 64'd1; cyc(); start = 1'b0;
        capture(9'h0AB, 9'h0CD, lat);
        chk("bp_lat", 32'(lat), 32'd4);
        chk("bp_dat", 32'(dat), 32'hABCD);
        for (int i = 0; i < 10; i++) begin
            cyc();
            mul     = 18'h3FFFF;
            mul_val = (i == 3);
            start   = (i == 5);
            iter    = 64'd1;
            @(negedge clk);
            chk("bp_hold_val", 32'(val), 32'd1);
            chk("bp_hold_dat", 32'(dat), 32'hABCD);
        end
        cyc();
        mul_val = 1'b0; start = 1'b0; rdy = 1'b1;
        @(negedge clk);
        chk("bp_xfer_val",  32'(val),  32'd1);
        chk("bp_xfer_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("bp_after_val",  32'(val),  32'd0);
        chk("bp_after_busy", 32'(busy), 32'd0);
        cyc();

        // Pulse coincident with start is not counted; restart while busy ignored.
        start = 1'b1; iter = 64'd1; mul = {9'h1FF, 9'h1FF}; mul_val = 1'b1;
        cyc();
        start = 1'b0; mul_val = 1'b0;
        @(negedge clk);
        chk("sr_busy", 32'(busy), 32'd1);
        cyc();
        start = 1'b1; iter = 64'd5; cyc(); start = 1'b0;
        @(negedge clk);
        chk("sr_no_err", 32'(err), 32'd0);
        cyc();
        capture(9'h022, 9'h011, lat);
        chk("sr_lat", 32'(lat), 32'd4);
        chk("sr_dat", 32'(dat), 32'h2211);
        cyc();

        // Zero iteration count.
        start = 1'b1; iter = 64'd0; cyc(); start = 1'b0;
        @(negedge clk);
        chk("zero_err",   32'(err),    32'd1);
        chk("zero_busy",  32'(busy),   32'd0);
        chk("zero_e_err", 32'(e_err),  32'd1);
        @(negedge clk);
        chk("zero_err_pulse", 32'(err), 32'd0);
        cyc();

        // acc=0x1FFFF: two subtractions normally, overrun with MAX_SUB=1.
        start = 1'b1; iter = 64'd1; cyc(); start = 1'b0;
        mul = {9'h1FF, 9'h0FF}; mul_val = 1'b1;
        @(negedge clk);
        cyc();
        mul_val = 1'b0;
        lat_a = 99; lat_e = 99; nerr = 0; nval_e = 0; dat_a = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (val && lat_a == 99) begin
                lat_a = n;
                dat_a = dat;
            end
            if (e_err) begin
                nerr++;
                if (lat_e == 99) lat_e = n;
            end
            if (e_val) nval_e++;
        end
        chk("twosub_lat",  32'(lat_a),  32'd6);
        chk("twosub_dat",  32'(dat_a),  32'h7FFD);
        chk("ovr_err_lat", 32'(lat_e),  32'd5);
        chk("ovr_err_cnt", 32'(nerr),   32'd1);
        chk("ovr_no_val",  32'(nval_e), 32'd0);
        chk("ovr_idle",    32'(e_busy), 32'd0);
        cyc();

        // Asynchronous reset while in PROP, then a fresh T=2 run.
        start = 1'b1; iter = 64'd1; cyc(); start = 1'b0;
        mul = {9'h010, 9'h005}; mul_val = 1'b1; cyc(); mul_val = 1'b0;
        @(negedge clk);
        chk("mid_pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   32'(busy),   32'd0);
        chk("mid_rst_val",    32'(val),    32'd0);
        chk("mid_rst_err",    32'(err),    32'd0);
        chk("mid_rst_e_busy", 32'(e_busy), 32'd0);
        cyc();
        rst_n = 1'b1;
        start = 1'b1; iter = 64'd2; cyc(); start = 1'b0;
        pulse(9'h1C3, 9'h0E7);
        capture(9'h033, 9'h044, lat);
        chk("fresh_lat", 32'(lat), 32'd4);
        chk("fresh_dat", 32'(dat), 32'h3344);
        @(negedge clk);
        chk("fresh_done_val",  32'(val),  32'd0);
        chk("fresh_done_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
